// File: rtl/q_episode_ctrl_if.sv
// rtl/q_episode_ctrl_if.sv - handshake bundle between the episode sequencer and the Q-learning datapath
interface q_episode_ctrl_if #(
  parameter int STATES_WIDTH  = 4,
  parameter int ACTIONS_WIDTH = 2
);
  logic                     i_run;
  logic [STATES_WIDTH-1:0]  i_first_st;
  logic [ACTIONS_WIDTH-1:0] i_greedy_at;
  logic [STATES_WIDTH-1:0]  i_st;
  logic                     i_valid_st;
  logic                     i_upd_done;
  logic                     o_start;
  logic [STATES_WIDTH-1:0]  o_first_st;
  logic [ACTIONS_WIDTH-1:0] o_at;
  logic                     o_valid_at;
  logic                     o_finish;
  logic                     o_busy;
  logic [15:0]              o_episode_cnt;
  logic [15:0]              o_step_cnt;

  modport master (
    input  i_run, i_first_st, i_greedy_at, i_st, i_valid_st, i_upd_done,
    output o_start, o_first_st, o_at, o_valid_at, o_finish, o_busy, o_episode_cnt, o_step_cnt
  );

  modport slave (
    output i_run, i_first_st, i_greedy_at, i_st, i_valid_st, i_upd_done,
    input  o_start, o_first_st, o_at, o_valid_at, o_finish, o_busy, o_episode_cnt, o_step_cnt
  );
endinterface

// File: rtl/q_episode_ctrl.sv
// rtl/q_episode_ctrl.sv - epsilon-greedy episode sequencer for the Q-learning datapath
module q_episode_ctrl #(
  parameter int         STATES_WIDTH  = 4,
  parameter int         ACTIONS       = 4,
  parameter int         ACTIONS_WIDTH = 2,
  parameter int         MAX_STEPS     = 16,
  parameter int         NUM_EPISODES  = 64,
  parameter int         GOAL_STATE    = 15,
  parameter logic [7:0] EPS_THRESH    = 8'd26,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  q_episode_ctrl_if.master bus
);

  generate
    if (((ACTIONS & (ACTIONS - 1)) != 0) || (ACTIONS != (1 << ACTIONS_WIDTH))) begin : g_bad_actions
      $error("ACTIONS must be a power of two equal to 2**ACTIONS_WIDTH");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
      $error("LFSR_SEED must be non-zero");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_UPD, S_EP_END, S_FINISH, S_DONE
  } state_t;

  localparam logic [STATES_WIDTH-1:0] GOAL = STATES_WIDTH'(GOAL_STATE);

  state_t                    state, state_nxt;
  logic [7:0]                lfsr;
  logic                      goal_flag;
  logic [STATES_WIDTH-1:0]   first_st;
  logic [15:0]               episode_cnt, step_cnt;
  logic                      goal_now, last_step, last_episode, ep_done;
  logic                      start_pulse, valid_at, finish_pulse;
  logic [ACTIONS_WIDTH-1:0]  act;

  // goal reported alongside the write-back still closes that step's episode
  assign goal_now     = goal_flag | (bus.i_valid_st && (bus.i_st == GOAL));
  assign last_step    = ({1'b0, step_cnt} + 17'd1) == 17'(MAX_STEPS);
  assign last_episode = ({1'b0, episode_cnt} + 17'd1) == 17'(NUM_EPISODES);
  assign ep_done      = goal_now || last_step;
  assign act          = (lfsr < EPS_THRESH) ? lfsr[ACTIONS_WIDTH-1:0] : bus.i_greedy_at;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_pulse  = 1'b0;
    valid_at     = 1'b0;
    finish_pulse = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (bus.i_run) state_nxt = S_START;
      S_START: begin
        start_pulse = 1'b1;
        valid_at    = 1'b1;
        state_nxt   = S_WAIT_UPD;
      end
      S_WAIT_UPD: begin
        if (bus.i_upd_done) begin
          if (ep_done) state_nxt = S_EP_END;
          else         valid_at  = 1'b1;
        end
      end
      S_EP_END: state_nxt = last_episode ? S_FINISH : S_START;
      S_FINISH: begin
        finish_pulse = 1'b1;
        state_nxt    = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= LFSR_SEED;
      goal_flag   <= 1'b0;
      first_st    <= '0;
      episode_cnt <= '0;
      step_cnt    <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.i_run) begin
            first_st    <= bus.i_first_st;
            episode_cnt <= '0;
            step_cnt    <= '0;
            goal_flag   <= 1'b0;
          end
        end
        S_WAIT_UPD: begin
          if (bus.i_valid_st && (bus.i_st == GOAL)) goal_flag <= 1'b1;
          if (bus.i_upd_done && (step_cnt != 16'hFFFF)) step_cnt <= step_cnt + 16'd1;
        end
        S_EP_END: begin
          if (episode_cnt != 16'hFFFF) episode_cnt <= episode_cnt + 16'd1;
          step_cnt  <= '0;
          goal_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_start       = start_pulse;
  assign bus.o_valid_at    = valid_at;
  assign bus.o_at          = valid_at ? act : '0;
  assign bus.o_finish      = finish_pulse;
  assign bus.o_busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.o_first_st    = first_st;
  assign bus.o_episode_cnt = episode_cnt;
  assign bus.o_step_cnt    = step_cnt;

endmodule
